// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StGap
  } uart_arb_state_t;

  localparam int unsigned FRAME_BITS_DEFAULT = 10;

  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned frame_bits);
    return clks_per_bit * frame_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int unsigned IdxW = $clog2(N);

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] p,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= N) s = s - N;
    return s[IdxW-1:0];
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    if (enable) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any && req[wrap_idx(ptr, i)]) begin
          any                    = 1'b1;
          grant_idx              = wrap_idx(ptr, i);
          grant[wrap_idx(ptr, i)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; frames are timed locally.
// Define UART_TX_ARB_GAP_EN to insert one idle bit time after every frame.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FRAME_BITS   = FRAME_BITS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic                        o_tx_start,
  output logic [DATA_W-1:0]           o_tx_data,
  output logic                        o_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id
);

  localparam int unsigned FrameCycles = frame_cycles(CLKS_PER_BIT, FRAME_BITS);
  localparam int unsigned CntW        = $clog2(FrameCycles);
  localparam int unsigned IdxW        = $clog2(NUM_REQ);

  uart_arb_state_t   state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0] win_grant;
  logic [IdxW-1:0]    win_idx;
  logic               win_any;
  logic               arb_en;

  // Ready is held low during reset so no byte is consumed on a discarded edge.
  assign arb_en = (state_q == StIdle) && !i_reset;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req      (i_req_valid),
    .ptr      (rr_ptr_q),
    .enable   (arb_en),
    .grant    (win_grant),
    .grant_idx(win_idx),
    .any      (win_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          tx_data_d  = i_req_data[win_idx*DATA_W +: DATA_W];
          grant_id_d = win_idx;
          rr_ptr_d   = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        cnt_d   = CntW'(FrameCycles - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
`ifdef UART_TX_ARB_GAP_EN
          cnt_d   = CntW'(CLKS_PER_BIT - 1);
          state_d = StGap;
`else
          state_d = StIdle;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_TX_ARB_GAP_EN
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_req_ready = win_grant;
  assign o_tx_start  = (state_q == StStart);
  assign o_busy      = (state_q != StIdle);
  assign o_tx_data   = tx_data_q;
  assign o_grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with CLKS_PER_BIT=4, NUM_REQ=4 (F=40).
module tb_uart_tx_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 8;
  localparam int unsigned Cpb  = 4;
  localparam int          F    = 40;
`ifdef UART_TX_ARB_GAP_EN
  localparam int          Gap  = Cpb;
`else
  localparam int          Gap  = 0;
`endif
  localparam int          Fg   = F + Gap;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic [NReq-1:0]      i_req_valid = '0;
  logic [NReq*Dw-1:0]   i_req_data = '0;
  logic [NReq-1:0]      o_req_ready;
  logic                 o_tx_start;
  logic [Dw-1:0]        o_tx_data;
  logic                 o_busy;
  logic [1:0]           o_grant_id;

  uart_tx_arbiter #(
    .NUM_REQ     (NReq),
    .DATA_W      (Dw),
    .CLKS_PER_BIT(Cpb),
    .FRAME_BITS  (10)
  ) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_req_valid(i_req_valid),
    .i_req_data (i_req_data),
    .o_req_ready(o_req_ready),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_grant_id (o_grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    int         gap;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_start = 0;
  logic prev_start = 1'b0;

  logic [7:0] bytes [NReq][2];
  int         idx   [NReq];
  int         left  [NReq];

  logic            s_start, s_busy;
  logic [7:0]      s_data;
  logic [1:0]      s_id;
  logic [NReq-1:0] s_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] id, input int gap);
    exp_t e;
    e.data = d;
    e.id   = id;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic load_req(input int k, input logic [7:0] b0, input logic [7:0] b1,
                          input int n);
    bytes[k][0] = b0;
    bytes[k][1] = b1;
    idx[k]      = 0;
    left[k]     = n;
    i_req_valid[k] = 1'b1;
    i_req_data[k*Dw +: Dw] = b0;
  endtask

  // Sample one cycle at the falling edge, check start pulses against the scoreboard,
  // then advance each requester past any byte consumed at the rising edge.
  task automatic tick();
    logic [NReq-1:0] hs;
    exp_t e;
    @(negedge clk);
    s_start = o_tx_start;
    s_busy  = o_busy;
    s_data  = o_tx_data;
    s_id    = o_grant_id;
    s_ready = o_req_ready;
    hs      = o_req_ready & i_req_valid;
    if (prev_start) chk("start_len", 32'(s_start), 0);
    if (s_start) begin
      if (sb.size() == 0) begin
        chk("sb_empty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("tx_data", 32'(s_data), 32'(e.data));
        chk("grant_id", 32'(s_id), 32'(e.id));
        if (e.gap != 0) chk("start_gap", cyc - last_start, e.gap);
      end
      last_start = cyc;
    end
    prev_start = s_start;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < int'(NReq); k++) begin
      if (hs[k]) begin
        left[k]--;
        idx[k]++;
        if (left[k] <= 0) i_req_valid[k] = 1'b0;
        else i_req_data[k*Dw +: Dw] = bytes[k][idx[k]];
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sb.size() == 0 && !s_busy) && n < budget);
    if (!(sb.size() == 0 && !s_busy)) chk("drain_timeout", 32'(sb.size()) + 32'(s_busy), 0);
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    i_req_valid = '0;
    for (int k = 0; k < int'(NReq); k++) left[k] = 0;
    sb.delete();
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    // Reset values
    do_reset();
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_data", 32'(s_data), 0);
    chk("rst_id", 32'(s_id), 0);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_start", 32'(s_start), 0);

    // Single requester with two bytes: exact handshake, busy window, re-grant cycle
    load_req(2, 8'hA5, 8'h5A, 2);
    push(8'hA5, 2'd2, 0);
    push(8'h5A, 2'd2, Fg + 2);
    tick();
    chk("single_ready_T", 32'(s_ready), 32'b0100);
    t0 = cyc - 1;
    tick();
    chk("single_start_T1", 32'(s_start), 1);
    chk("single_busy_T1", 32'(s_busy), 1);
    repeat (Fg) tick();
    chk("single_busy_last", 32'(s_busy), 1);
    chk("single_last_cyc", cyc - 1 - t0, Fg + 1);
    tick();
    chk("single_idle_busy", 32'(s_busy), 0);
    chk("single_ready_again", 32'(s_ready), 32'b0100);
    drain(200);

    // Simultaneous req0/req1 from reset
    do_reset();
    load_req(0, 8'h11, 8'h00, 1);
    load_req(1, 8'h22, 8'h00, 1);
    push(8'h11, 2'd0, 0);
    push(8'h22, 2'd1, Fg + 2);
    tick();
    chk("sim_ready_first", 32'(s_ready), 32'b0001);
    drain(300);

    // Fairness: all four continuously valid for eight frames
    do_reset();
    for (int k = 0; k < int'(NReq); k++) load_req(k, 8'h30 + 8'(k), 8'h40 + 8'(k), 2);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < int'(NReq); k++) begin
        push((r == 0) ? 8'h30 + 8'(k) : 8'h40 + 8'(k), 2'(k), (r == 0 && k == 0) ? 0 : Fg + 2);
      end
    end
    drain(8 * (Fg + 2) + 50);

    // Withdrawal: req3 pulses valid while a frame is in flight
    do_reset();
    load_req(0, 8'h77, 8'h00, 1);
    push(8'h77, 2'd0, 0);
    tick();
    tick();
    i_req_valid[3] = 1'b1;
    i_req_data[3*Dw +: Dw] = 8'h99;
    repeat (10) tick();
    i_req_valid[3] = 1'b0;
    drain(200);
    repeat (3) tick();
    chk("wd_busy", 32'(s_busy), 0);
    chk("wd_data", 32'(s_data), 32'h77);
    chk("wd_id", 32'(s_id), 0);
    chk("wd_ready", 32'(s_ready), 0);

    // Reset mid-frame with req1 pending
    do_reset();
    load_req(0, 8'h55, 8'h00, 1);
    push(8'h55, 2'd0, 0);
    tick();
    tick();
    repeat (10) tick();
    i_reset = 1'b1;
    load_req(1, 8'h66, 8'h00, 1);
    tick();
    tick();
    chk("mid_rst_busy", 32'(s_busy), 0);
    chk("mid_rst_data", 32'(s_data), 0);
    chk("mid_rst_id", 32'(s_id), 0);
    chk("mid_rst_ready", 32'(s_ready), 0);
    i_reset = 1'b0;
    push(8'h66, 2'd1, 0);
    tick();
    chk("post_rst_ready", 32'(s_ready), 32'b0010);
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_transmitter` between `NUM_REQ` byte producers. Arbitrates round-robin among requesters over a valid/ready handshake, then drives the transmitter's data and start inputs. The transmitter has no done/busy output, so this block times each frame with its own bit-period counter. It sits directly in front of the transmitter; the transmitter's `o_tx` goes to the pin.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_W`, 8, byte width
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (must match the transmitter)
- `FRAME_BITS`, 10, bits per frame (start + 8 data + stop)
- `clk`  in  1  system clock, all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_req_valid`  in  NUM_REQ  per-requester byte valid
- `i_req_data`  in  NUM_REQ*DATA_W  per-requester byte; requester k occupies bits [k*DATA_W +: DATA_W]
- `o_req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero
- `o_tx_start`  out  1  one-cycle start pulse to the transmitter
- `o_tx_data`  out  DATA_W  byte to the transmitter; held stable for the whole frame
- `o_busy`  out  1  frame in progress
- `o_grant_id`  out  $clog2(NUM_REQ)  index of the last granted requester

## Operation
- States: IDLE, START, WAIT, GAP. GAP exists only with the macro; see Configuration.
- **IDLE:**
  - If any `i_req_valid` is set, the winner is the first valid index at or after `rr_ptr`, searching upward and wrapping.
  - `o_req_ready[winner]` is combinational and asserted only in IDLE.
  - A handshake occurs when valid and ready are both high. It latches the winner's byte into `o_tx_data`, loads `o_grant_id` with the winner, sets `rr_ptr` to winner+1 (wrapping NUM_REQ-1 to 0), and moves to START.
- **START:** `o_tx_start` is 1 for exactly this cycle. Frame counter is loaded with `CLKS_PER_BIT*FRAME_BITS-1`; go to WAIT.
- **WAIT:** counter decrements each cycle. On reaching 0, go to IDLE (or GAP).
- Requester rules:
  - A requester holds valid and data stable until it sees ready.
  - Lowering valid before ready is legal; the request is simply withdrawn.
  - Only the winner's byte is consumed. Losers see ready=0.
- Counter width is `$clog2(CLKS_PER_BIT*FRAME_BITS)`. No wrap-around is possible.
- Reset (any state, including mid-frame) returns to IDLE on the next edge. Reset values:
  - `o_tx_start`=0, `o_tx_data`=0, `o_busy`=0, `o_grant_id`=0, `o_req_ready`=0
  - `rr_ptr`=0, counter=0
  - A frame cut by reset is abandoned; the transmitter is reset by the same `i_reset`.

## Timing
- Handshake at cycle T gives:
  - `o_tx_start`=1 at T+1 only.
  - WAIT occupies T+2 through T+1+F, where F=`CLKS_PER_BIT*FRAME_BITS`.
  - IDLE again at T+2+F, and ready may assert in that cycle.
- Back-to-back grant spacing: F+2 cycles without gap; F+2+CLKS_PER_BIT with gap.
- `o_busy` is 1 from T+1 through the last WAIT/GAP cycle, and 0 whenever in IDLE.
- `o_tx_data` and `o_grant_id` change only on a handshake edge and otherwise hold.
- Simultaneous valids: exactly one grant per IDLE cycle. Every continuously-valid requester is served within NUM_REQ grants.

## Configuration
- `UART_TX_ARB_GAP_EN` defined:
  - WAIT at 0 goes to GAP.
  - GAP counts `CLKS_PER_BIT` cycles with `o_busy`=1 and `o_tx_start`=0, then goes to IDLE.
  - This guarantees one idle bit time between frames.
- Not defined: the GAP state and its logic are absent, and WAIT goes straight to IDLE.

## Structure
- Package `uart_tx_pkg` holds:
  - state enum `uart_arb_state_t` (IDLE, START, WAIT, GAP)
  - `FRAME_BITS_DEFAULT`=10
  - a function returning the frame-cycle count from `CLKS_PER_BIT` and `FRAME_BITS`
- One sub-module, `rr_arbiter`:
  - parameter `N`
  - inputs: `req`, `ptr`, `enable`
  - outputs: one-hot `grant`, `grant_idx`, `any`
  - purely combinational, with the rotate-and-priority-encode done there
  - `rr_ptr` register lives in the top

## Test plan
Use `CLKS_PER_BIT`=4 and `NUM_REQ`=4, so F=40.
- Single request: only req2 valid with 0xA5 → ready[2] at T; `o_tx_start` pulse at T+1 with `o_tx_data`=0xA5 and `o_grant_id`=2; `o_busy` high T+1..T+41; ready returns at T+42.
- Simultaneous req0=0x11 and req1=0x22 from reset → 0x11 granted first; 0x22 start pulse exactly 42 cycles after the first.
- Fairness: all four valid continuously for 8 frames → grant order 0,1,2,3,0,1,2,3; each start pulse lasts 1 cycle.
- Withdrawal: req3 raises then drops valid while busy with req0 → no grant to 3; next IDLE with no valid keeps `o_busy`=0 and `o_tx_data` unchanged.
- Reset mid-frame: assert `i_reset` 10 cycles into WAIT → next edge gives `o_busy`=0, `o_tx_data`=0, `o_grant_id`=0, IDLE; a pending req1 is granted the cycle after reset deasserts.
- With `UART_TX_ARB_GAP_EN`, repeat the simultaneous req0/req1 case → start pulses 46 cycles apart, `o_busy` continuous through the gap.
